lfsr_deser: RTL and testbench

- Downstream consumer of the LFSR pattern generator's serial output.
- Samples the generator's 1-bit OUT/Valid stream and assembles WIDTH consecutive valid bits into a parallel word. The first bit received goes to bit 0 (the generator shifts LSB first).
- Presents each completed word with a one-cycle strobe.
- Detects broken frames (valid gaps longer than GAP_MAX) and keeps saturating word and error counts for bring-up and debug.

---
 rtl/lfsr_deser.sv | 90 +++++++++
 tb/tb_lfsr_deser.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_deser.sv
// lfsr_deser: assembles LSB-first serial words with gap detection; LFSR_DESER_EXPECT_CHECK_EN adds an expected-word compare
module lfsr_deser #(
  parameter int WIDTH   = 4,
  parameter int GAP_MAX = 2,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ser_in,
  input  logic             ser_valid,
`ifdef LFSR_DESER_EXPECT_CHECK_EN
  input  logic [WIDTH-1:0] exp_word,
  output logic             mismatch,
`endif
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = $clog2(GAP_MAX + 2);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, word;
  logic [BW-1:0] bit_cnt, bit_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic done, abort;
  assign word = {ser_in, shreg[WIDTH-1:1]};
  assign busy = (state == COLLECT);
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    done    = 1'b0;
    abort   = 1'b0;
    if (ser_valid) begin
      shreg_n = word;
      gap_n   = '0;
      if (state == IDLE) begin
        bit_n   = BW'(1);
        state_n = COLLECT;
      end else if (bit_cnt == BW'(WIDTH - 1)) begin
        done    = 1'b1;
        bit_n   = '0;
        state_n = IDLE;
      end else
        bit_n = bit_cnt + BW'(1);
    end else if (state == COLLECT) begin
      // a gap one longer than GAP_MAX breaks the frame
      if (gap_cnt == GW'(GAP_MAX)) begin
        abort   = 1'b1;
        state_n = IDLE;
        bit_n   = '0;
        gap_n   = '0;
        shreg_n = '0;
      end else
        gap_n = gap_cnt + GW'(1);
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      par_out   <= '0;
      par_valid <= 1'b0;
      frame_err <= 1'b0;
      word_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_n;
      gap_cnt   <= gap_n;
      par_out   <= done ? word : par_out;
      par_valid <= done;
      frame_err <= abort;
      word_cnt  <= word_cnt + CNT_W'(done && word_cnt != '1);
      err_cnt   <= err_cnt + CNT_W'(abort && err_cnt != '1);
    end
  end
`ifdef LFSR_DESER_EXPECT_CHECK_EN
  always_ff @(posedge CLK)
    mismatch <= RST ? 1'b0 : (done && word != exp_word);
`endif
endmodule

// File: tb/tb_lfsr_deser.sv
// tb_lfsr_deser: directed checks of lfsr_deser; a second CNT_W=2 instance covers counter saturation
module tb_lfsr_deser;
  logic CLK = 1'b0, RST, ser_in, ser_valid;
  logic [3:0] exp_word;
  logic [3:0] par_out, s_par_out;
  logic par_valid, frame_err, busy, s_par_valid, s_frame_err, s_busy;
  logic [7:0] word_cnt, err_cnt;
  logic [1:0] s_word_cnt, s_err_cnt;
  logic m_mis, s_mis;
  int vectors = 0, miscompares = 0;

  always #5 CLK = ~CLK;

  lfsr_deser #(.WIDTH(4), .GAP_MAX(2), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .ser_in(ser_in), .ser_valid(ser_valid),
`ifdef LFSR_DESER_EXPECT_CHECK_EN
    .exp_word(exp_word), .mismatch(m_mis),
`endif
    .par_out(par_out), .par_valid(par_valid), .frame_err(frame_err),
    .busy(busy), .word_cnt(word_cnt), .err_cnt(err_cnt));

  lfsr_deser #(.WIDTH(4), .GAP_MAX(2), .CNT_W(2)) u_sat (
    .CLK(CLK), .RST(RST), .ser_in(ser_in), .ser_valid(ser_valid),
`ifdef LFSR_DESER_EXPECT_CHECK_EN
    .exp_word(exp_word), .mismatch(s_mis),
`endif
    .par_out(s_par_out), .par_valid(s_par_valid), .frame_err(s_frame_err),
    .busy(s_busy), .word_cnt(s_word_cnt), .err_cnt(s_err_cnt));

`ifndef LFSR_DESER_EXPECT_CHECK_EN
  assign m_mis = 1'b0;
  assign s_mis = 1'b0;
`endif

  task automatic step(input logic v, input logic b);
    ser_valid = v;
    ser_in    = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic send4(input logic [3:0] w);
    for (int i = 0; i < 4; i++) step(1'b1, w[i]);
  endtask

  task automatic do_reset;
    RST = 1'b1;
    step(1'b0, 1'b0);
    RST = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++;
    if ({par_out, par_valid, frame_err, busy, word_cnt, err_cnt} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset: got par_out=%b pv=%b fe=%b busy=%b wc=%0d ec=%0d, want all 0",
               par_out, par_valid, frame_err, busy, word_cnt, err_cnt);
    end
  endtask

  task automatic test_basic;
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
    vectors++;
    if (busy !== 1'b1 || par_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_mid: got busy=%b pv=%b, want busy=1 pv=0", busy, par_valid);
    end
    step(1'b1, 1'b1);
    vectors++;
    if (par_out !== 4'b1101 || par_valid !== 1'b1 || word_cnt !== 8'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_word: got par_out=%b pv=%b wc=%0d busy=%b, want 1101 1 1 0",
               par_out, par_valid, word_cnt, busy);
    end
    step(1'b0, 1'b1);
    vectors++;
    if (par_valid !== 1'b0 || par_out !== 4'b1101 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_after: got pv=%b par_out=%b busy=%b, want 0 1101 0", par_valid, par_out, busy);
    end
  endtask

  task automatic test_back_to_back;
    do_reset();
    send4(4'b0001);
    vectors++;
    if (par_out !== 4'b0001 || par_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got par_out=%b pv=%b, want 0001 1", par_out, par_valid);
    end
    step(1'b1, 1'b0);
    vectors++;
    if (par_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_gapless: got pv=%b busy=%b, want 0 1", par_valid, busy);
    end
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1);
    vectors++;
    if (par_out !== 4'b1110 || par_valid !== 1'b1 || word_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL b2b_second: got par_out=%b pv=%b wc=%0d, want 1110 1 2", par_out, par_valid, word_cnt);
    end
  endtask

  task automatic test_gap_ok;
    logic fe_seen = 1'b0;
    do_reset();
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b0, 1'b0); fe_seen |= frame_err;
    step(1'b0, 1'b1); fe_seen |= frame_err;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL gap_ok_busy: got busy=%b, want 1", busy);
    end
    step(1'b1, 1'b0); fe_seen |= frame_err;
    step(1'b1, 1'b1); fe_seen |= frame_err;
    vectors++;
    if (par_out !== 4'b1011 || par_valid !== 1'b1 || fe_seen !== 1'b0 || err_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL gap_ok_word: got par_out=%b pv=%b fe_seen=%b ec=%0d, want 1011 1 0 0",
               par_out, par_valid, fe_seen, err_cnt);
    end
  endtask

  task automatic test_gap_abort;
    do_reset();
    send4(4'b1101);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    vectors++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_early: got fe=%b busy=%b, want 0 1", frame_err, busy);
    end
    step(1'b0, 1'b0);
    vectors++;
    if (frame_err !== 1'b1 || par_valid !== 1'b0 || err_cnt !== 8'd1 || par_out !== 4'b1101 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_pulse: got fe=%b pv=%b ec=%0d par_out=%b busy=%b, want 1 0 1 1101 0",
               frame_err, par_valid, err_cnt, par_out, busy);
    end
    step(1'b0, 1'b0);
    vectors++;
    if (frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_one_cycle: got fe=%b, want 0", frame_err);
    end
    send4(4'b1100);
    vectors++;
    if (par_out !== 4'b1100 || par_valid !== 1'b1 || word_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL abort_fresh: got par_out=%b pv=%b wc=%0d, want 1100 1 2", par_out, par_valid, word_cnt);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    send4(4'b1001);
    step(1'b1, 1'b1); step(1'b1, 1'b1);
    do_reset();
    vectors++;
    if ({par_out, par_valid, frame_err, busy, word_cnt, err_cnt} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got par_out=%b pv=%b fe=%b busy=%b wc=%0d ec=%0d, want all 0",
               par_out, par_valid, frame_err, busy, word_cnt, err_cnt);
    end
    send4(4'b0110);
    vectors++;
    if (par_out !== 4'b0110 || par_valid !== 1'b1 || word_cnt !== 8'd1) begin
      miscompares++;
      $display("FAIL reset_mid_word: got par_out=%b pv=%b wc=%0d, want 0110 1 1", par_out, par_valid, word_cnt);
    end
  endtask

  task automatic test_saturation;
    logic [3:0] words [5] = '{4'b1101, 4'b0101, 4'b1101, 4'b1101, 4'b1101};
    do_reset();
    exp_word = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      send4(words[i]);
      vectors++;
      if (s_word_cnt !== 2'((i + 1 > 3) ? 3 : i + 1) || word_cnt !== 8'(i + 1) || s_par_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_word%0d: got s_wc=%0d wc=%0d s_pv=%b, want %0d %0d 1",
                 i, s_word_cnt, word_cnt, s_par_valid, (i + 1 > 3) ? 3 : i + 1, i + 1);
      end
`ifdef LFSR_DESER_EXPECT_CHECK_EN
      vectors++;
      if (s_mis !== (i == 1) || m_mis !== (i == 1)) begin
        miscompares++;
        $display("FAIL mismatch%0d: got s_mis=%b m_mis=%b, want %b", i, s_mis, m_mis, i == 1);
      end
`endif
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      step(1'b0, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
      vectors++;
      if (s_err_cnt !== 2'((i + 1 > 3) ? 3 : i + 1) || err_cnt !== 8'(i + 1) || s_frame_err !== 1'b1) begin
        miscompares++;
        $display("FAIL sat_err%0d: got s_ec=%0d ec=%0d s_fe=%b, want %0d %0d 1",
                 i, s_err_cnt, err_cnt, s_frame_err, (i + 1 > 3) ? 3 : i + 1, i + 1);
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    ser_in = 1'b0;
    ser_valid = 1'b0;
    exp_word = 4'b1101;
    test_reset();
    test_basic();
    test_back_to_back();
    test_gap_ok();
    test_gap_abort();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
